// File: rtl/risc_datapath_if.sv
// Shared opcode type and the controller/memory-facing bus of the VeriRISC datapath.
// The master modport is the controller/memory side; the slave modport is the datapath.
package typedefs;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

interface risc_datapath_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
);
    import typedefs::*;

    logic              fetch;
    logic              load_ir;
    logic              load_ac;
    logic              load_pc;
    logic              inc_pc;
    logic              halt;
    logic [DWIDTH-1:0] mem_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    opcode_t           opcode;
    logic              zero;
    logic [AWIDTH-1:0] pc_out;
    logic              halted;

    modport master (
        output fetch, load_ir, load_ac, load_pc, inc_pc, halt, mem_rdata,
        input  mem_addr, mem_wdata, opcode, zero, pc_out, halted
    );

    modport slave (
        input  fetch, load_ir, load_ac, load_pc, inc_pc, halt, mem_rdata,
        output mem_addr, mem_wdata, opcode, zero, pc_out, halted
    );
endinterface

// File: rtl/risc_datapath.sv
// VeriRISC datapath: IR, PC, accumulator and ALU driven by controller strobes.
// State updates take 1 clk; opcode/zero/mem_addr are combinational from state; no backpressure.
module risc_datapath
    import typedefs::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
) (
    input logic             clk,
    input logic             reset,
    risc_datapath_if.slave  bus
);

    logic [DWIDTH-1:0] ir;
    logic [DWIDTH-1:0] ac;
    logic [AWIDTH-1:0] pc;
    logic              halted;
    logic [DWIDTH-1:0] alu_out;
    opcode_t           opcode;

    assign opcode = opcode_t'(ir[DWIDTH-1 -: 3]);

    // ALU is steered by the registered opcode, so a same-cycle load_ir sees the old instruction.
    always_comb begin
        alu_out = ac;
        case (opcode)
            ADD:     alu_out = ac + bus.mem_rdata;
            AND:     alu_out = ac & bus.mem_rdata;
            XOR:     alu_out = ac ^ bus.mem_rdata;
            LDA:     alu_out = bus.mem_rdata;
            default: alu_out = ac;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir     <= '0;
            ac     <= '0;
            pc     <= '0;
            halted <= 1'b0;
        end else begin
            if (bus.halt)
                halted <= 1'b1;
            // Blocking keys off the registered flag, so a strobe coincident with halt still lands.
            if (!halted) begin
                if (bus.load_ir)
                    ir <= bus.mem_rdata;
                if (bus.load_ac)
                    ac <= alu_out;
                if (bus.load_pc)
                    pc <= ir[AWIDTH-1:0];
                else if (bus.inc_pc)
                    pc <= pc + AWIDTH'(1);
            end
        end
    end

    assign bus.opcode    = opcode;
    assign bus.zero      = (ac == '0);
    assign bus.mem_addr  = bus.fetch ? pc : ir[AWIDTH-1:0];
    assign bus.mem_wdata = ac;
    assign bus.pc_out    = pc;
    assign bus.halted    = halted;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: stimulus pushes hand-computed expectations into a
// scoreboard queue; a negedge monitor pops and compares whenever a check is presented.
module tb_risc_datapath;
    import typedefs::*;

    typedef struct packed {
        logic [4:0] pc;
        logic [2:0] op;
        logic       zero;
        logic [7:0] wdata;
        logic       halted;
        logic [4:0] addr;
    } exp_t;

    logic clk;
    logic reset;
    logic obs_vld;
    int   checks;
    int   passed;

    exp_t  exp_q[$];
    string name_q[$];

    risc_datapath_if #(.DWIDTH(8), .AWIDTH(5)) bus();

    risc_datapath #(.DWIDTH(8), .AWIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (obs_vld) begin
            exp_t  e;
            exp_t  a;
            string n;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: got check with empty queue, required an expectation");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = '{pc: bus.pc_out, op: bus.opcode, zero: bus.zero, wdata: bus.mem_wdata,
                      halted: bus.halted, addr: bus.mem_addr};
                if (a === e)
                    passed = passed + 1;
                else
                    $display("FAIL %s: got pc=%h op=%0d zero=%b wdata=%h halted=%b addr=%h, required pc=%h op=%0d zero=%b wdata=%h halted=%b addr=%h",
                             n, a.pc, a.op, a.zero, a.wdata, a.halted, a.addr,
                             e.pc, e.op, e.zero, e.wdata, e.halted, e.addr);
            end
        end
    end

    task automatic clear_strobes();
        bus.load_ir = 1'b0;
        bus.load_ac = 1'b0;
        bus.load_pc = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.halt    = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic expect_state(input string n, input logic f, input logic [4:0] pc,
                                input logic [2:0] op, input logic z, input logic [7:0] wd,
                                input logic h, input logic [4:0] addr);
        bus.fetch = f;
        exp_q.push_back('{pc: pc, op: op, zero: z, wdata: wd, halted: h, addr: addr});
        name_q.push_back(n);
        obs_vld = 1'b1;
        @(negedge clk);
        #1;
        obs_vld = 1'b0;
    endtask

    task automatic load_ir_with(input logic [7:0] d);
        bus.mem_rdata = d;
        bus.load_ir   = 1'b1;
        cyc();
    endtask

    task automatic load_ac_with(input logic [7:0] d);
        bus.mem_rdata = d;
        bus.load_ac   = 1'b1;
        cyc();
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        obs_vld   = 1'b0;
        bus.fetch = 1'b1;
        bus.mem_rdata = 8'h00;
        clear_strobes();
        reset = 1'b1;
        cyc();
        expect_state("reset", 1, 5'h00, 3'd0, 1, 8'h00, 0, 5'h00);

        bus.fetch = 1'b1;
        load_ir_with(8'hA7);
        expect_state("fetch_ir", 0, 5'h00, 3'd5, 1, 8'h00, 0, 5'h07);
        load_ac_with(8'h3C);
        expect_state("lda", 0, 5'h00, 3'd5, 0, 8'h3C, 0, 5'h07);
        load_ac_with(8'hF0);
        expect_state("lda_f0", 0, 5'h00, 3'd5, 0, 8'hF0, 0, 5'h07);

        load_ir_with(8'h41);
        expect_state("add_ir", 0, 5'h00, 3'd2, 0, 8'hF0, 0, 5'h01);
        load_ac_with(8'h10);
        expect_state("add_wrap", 0, 5'h00, 3'd2, 1, 8'h00, 0, 5'h01);

        load_ir_with(8'h82);
        load_ac_with(8'h55);
        expect_state("xor", 0, 5'h00, 3'd4, 0, 8'h55, 0, 5'h02);

        load_ir_with(8'h63);
        load_ac_with(8'h0F);
        expect_state("and", 0, 5'h00, 3'd3, 0, 8'h05, 0, 5'h03);

        load_ir_with(8'hF2);
        load_ac_with(8'hFF);
        expect_state("jmp_ac_hold", 0, 5'h00, 3'd7, 0, 8'h05, 0, 5'h12);

        bus.load_pc = 1'b1;
        bus.inc_pc  = 1'b1;
        cyc();
        expect_state("jmp_beats_inc", 1, 5'h12, 3'd7, 0, 8'h05, 0, 5'h12);

        load_ir_with(8'hFF);
        bus.load_pc = 1'b1;
        cyc();
        expect_state("pc_31", 1, 5'h1F, 3'd7, 0, 8'h05, 0, 5'h1F);
        bus.inc_pc = 1'b1;
        cyc();
        expect_state("pc_wrap", 1, 5'h00, 3'd7, 0, 8'h05, 0, 5'h00);

        bus.inc_pc = 1'b1;
        cyc();
        bus.inc_pc = 1'b1;
        cyc();
        expect_state("skz_two_inc", 1, 5'h02, 3'd7, 0, 8'h05, 0, 5'h02);

        bus.mem_rdata = 8'h44;
        bus.load_ir   = 1'b1;
        bus.load_ac   = 1'b1;
        cyc();
        expect_state("ir_ac_same", 1, 5'h02, 3'd2, 0, 8'h05, 0, 5'h02);

        bus.inc_pc = 1'b1;
        cyc();
        bus.inc_pc = 1'b1;
        cyc();
        bus.halt   = 1'b1;
        bus.inc_pc = 1'b1;
        cyc();
        expect_state("halt_inc", 1, 5'h05, 3'd2, 0, 8'h05, 1, 5'h05);

        for (int i = 0; i < 5; i++) begin
            bus.mem_rdata = 8'hE1;
            bus.inc_pc    = 1'b1;
            bus.load_ac   = 1'b1;
            bus.load_ir   = 1'b1;
            bus.load_pc   = 1'b1;
            cyc();
        end
        expect_state("halt_block", 1, 5'h05, 3'd2, 0, 8'h05, 1, 5'h05);

        reset = 1'b1;
        cyc();
        expect_state("halt_reset", 1, 5'h00, 3'd0, 1, 8'h00, 0, 5'h00);

        load_ir_with(8'hA7);
        load_ac_with(8'h3C);
        bus.inc_pc = 1'b1;
        cyc();
        expect_state("pre_reset", 1, 5'h01, 3'd5, 0, 8'h3C, 0, 5'h01);

        bus.mem_rdata = 8'hBB;
        bus.load_ir   = 1'b1;
        bus.load_ac   = 1'b1;
        bus.inc_pc    = 1'b1;
        bus.halt      = 1'b1;
        reset         = 1'b1;
        cyc();
        expect_state("reset_midop", 0, 5'h00, 3'd0, 1, 8'h00, 0, 5'h00);

        repeat (2) @(negedge clk);
        while (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            checks = checks + 1;
            $display("FAIL unconsumed_%s: got no monitor sample, required a comparison", name_q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
